// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiplier that holds busy high for WIDTH cycles.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       AluS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;

  // Single-cycle operation result; unknown codes yield zero.
  always_comb begin
    alu_res = '0;
    case (AluS)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, one shift-add step per cycle in MUL.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (AluS == OP_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            count_d  = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // The last step commits the accumulator straight into Result.
        if (count_q == LAST_ITER) begin
          result_d = acc_step;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_MUL);
  assign done   = done_q;
  assign Result = result_q;
  assign Zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results with
// their due cycle, a negedge monitor pops and checks on every done pulse.
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam int MUL_LAT = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   AluS;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic         Zero;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .AluS   (AluS),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result),
    .Zero   (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (done && busy) begin
        errors++;
        $display("FAIL done_with_busy: actual done=1 busy=1 required not both");
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual Result=0x%08h at cycle %0d required no done", Result, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_result"}, Result, e.res);
          check({e.name, "_zero"}, {{(W-1){1'b0}}, Zero}, {{(W-1){1'b0}}, (e.res == '0)});
          check({e.name, "_latency"}, W'(cyc), W'(e.due));
          $display("txn %s: Result=0x%08h Zero=%0b cycle=%0d", e.name, Result, Zero, cyc);
        end
      end
    end
  end

  // Drive one request starting at a negedge; returns at the following negedge.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res);
    exp_t e;
    start = 1'b1; AluS = op; A = a; B = b;
    @(posedge clk); #1;
    e.res  = res;
    e.due  = cyc + ((op == 4'b0011) ? MUL_LAT : 0);
    e.name = name;
    exp_q.push_back(e);
    start = 1'b0;
    A = $urandom; B = $urandom;
    @(negedge clk);
  endtask

  // Count busy cycles until the multiply finishes (bounded).
  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, W'(n), W'(MUL_LAT));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; AluS = 4'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_zero", {31'b0, Zero}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    issue("add_7_5",  4'b0010, 32'd7, 32'd5, 32'd12);
    check("add_busy", {31'b0, busy}, 32'd0);
    issue("sub_5_5",  4'b0110, 32'd5, 32'd5, 32'd0);
    issue("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue("slt_1_m1", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0);
    issue("slt_min",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    issue("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    issue("or",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    issue("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1);
    issue("sub_wrap", 4'b0110, 32'd2, 32'd3, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    issue("mul_basic", 4'b0011, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
    count_busy("mul_basic");
    @(negedge clk);
    issue("mul_wrap", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    count_busy("mul_wrap");
    @(negedge clk);
    issue("mul_b1", 4'b0011, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF);
    count_busy("mul_b1");
    @(negedge clk);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue("mul_3_4", 4'b0011, 32'd3, 32'd4, 32'd12);
    repeat (4) @(negedge clk);
    start = 1'b1; AluS = 4'b0010; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    issue("add_after_mul", 4'b0010, 32'd1, 32'd1, 32'd2);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    issue("mul_abort", 4'b0011, 32'd9, 32'd9, 32'd81);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", Result, 32'd0);
    check("midrst_zero", {31'b0, Zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("bad_op", 4'b1111, 32'h1234_5678, 32'h0000_0001, 32'd0);
    issue("add_post", 4'b0010, 32'd40, 32'd2, 32'd42);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: actual cycle=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit AluS operation code produced by the ALU control decoder.
- Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in one clock.
- MUL (low word of the product) runs as an iterative shift-add over WIDTH cycles.
- A start/busy/done handshake lets the pipeline control stall the datapath while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only when busy=0.
- AluS  input  4  operation code; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a MUL is in progress.
- done  output  1  one-cycle pulse; Result/Zero valid and updated in the same cycle.
- Result  output  WIDTH  registered result, held until the next completion.
- Zero  output  1  high when Result == 0; derived from registered Result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, Result=0, Zero=1, multiply counter/accumulator cleared.
- Opcode map:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wrap mod 2^WIDTH, no carry out)
  - 0110 SUB (A-B, wrap)
  - 0111 SLT (signed two's-complement compare; Result = {0...,1} if A<B, else 0)
  - 0011 MUL (low WIDTH bits of A*B; identical for signed and unsigned)
  - any other code: Result=0, completes as single-cycle.
- FSM states: IDLE, MUL.
- IDLE, start=1, non-MUL code at edge k:
  - Result latched at edge k; done=1 during cycle k..k+1.
  - State remains IDLE; busy stays 0.
- IDLE, start=1, AluS=0011 at edge k:
  - Load mcand=A, mplier=B, acc=0, count=0; go to MUL; busy=1 from edge k.
- MUL, each edge:
  - If mplier[0]=1, acc += mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - Final iteration (count == WIDTH-1, edge k+WIDTH): Result = final acc, done=1, busy=0, return to IDLE.
  - Total latency: WIDTH cycles from accepting edge to done; busy high for exactly WIDTH cycles.
- done is high for exactly one cycle per accepted operation and never high while busy=1.
- start while busy=1: ignored entirely; inputs not sampled, no extra done pulse.
- Back-to-back: start may be asserted in the done cycle of the previous op (state is IDLE) and is accepted at the next edge; single-cycle ops can issue every cycle, giving a done pulse every cycle.
- Result and Zero change only at a completion edge or at reset; they hold otherwise.
- Operands change during MUL: no effect; internal copies are used.
- Reset mid-MUL: operation aborted, all outputs return to reset values immediately, no done pulse; first start after rst_n deasserts is accepted normally.
- No early termination for MUL, even if B becomes 0 early; latency is fixed at WIDTH.

Test Plan:
- ADD, SUB, Zero flag:
  - start, AluS=0010, A=7, B=5 -> next cycle done=1, Result=12, Zero=0, busy=0 throughout.
  - Then AluS=0110, A=5, B=5 -> Result=0, Zero=1.
- SLT signed compare: AluS=0111, A=0xFFFFFFFF, B=1 -> Result=1.
  - Swap operands -> Result=0.
  - AND 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xF000_F000.
  - OR of the same operands -> 0xFFF0_FFF0.
- MUL basic: AluS=0011, A=0x0000_1234, B=0x0000_0010 -> busy=1 for exactly 32 cycles, done pulses once at cycle 32, Result=0x0001_2340.
- MUL wrap: A=0xFFFFFFFF, B=0xFFFFFFFF -> Result=0x0000_0001 after 32 cycles.
- Issue during busy:
  - Start MUL 3*4; at cycle 5 pulse start with ADD 1+1 -> ignored, single done at cycle 32, Result=12.
  - Start asserted in that done cycle (ADD 1+1) -> accepted, done next cycle, Result=2.
- Reset mid-MUL and bad opcode:
  - Deassert rst_n at cycle 10 of a MUL -> busy=0, done=0, Result=0, Zero=1 immediately.
  - After release, AluS=1111 with start -> done next cycle, Result=0.
